// File: rtl/mealy_pkg.sv
// Shared helpers for mealy_pattern_matcher: index/fill width function and default geometry.
package mealy_pkg;

    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    localparam int DEF_PAT_LEN = 3;
    localparam int DEF_NUM_PAT = 2;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_FILL_W  = clog2_min1(DEF_PAT_LEN);
    localparam int DEF_IDX_W   = clog2_min1(DEF_NUM_PAT);

    typedef logic [DEF_FILL_W-1:0] fill_t;
    typedef logic [DEF_IDX_W-1:0]  idx_t;

endpackage

// File: rtl/mealy_pat_slot.sv
// One pattern slot: programmable pattern register, comparator and, with
// MEALY_HIT_COUNT_EN defined, a saturating hit counter.
module mealy_pat_slot
    import mealy_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter int                 IDX_W   = DEF_IDX_W,
    parameter int                 SLOT    = 0,
`ifdef MEALY_HIT_COUNT_EN
    parameter int                 CNT_W   = DEF_CNT_W,
`endif
    parameter logic [PAT_LEN-1:0] RST_PAT = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               match_en,
    input  logic [PAT_LEN-1:0] window,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [PAT_LEN-1:0] cfg_pattern,
`ifdef MEALY_HIT_COUNT_EN
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   hit_cnt,
`endif
    output logic               hit
);

    logic [PAT_LEN-1:0] pat_q;
    logic [PAT_LEN-1:0] pat_d;

    // The comparator sees pat_q, so a write in the same cycle only affects later samples.
    assign hit = match_en && (window == pat_q);

    always_comb begin
        pat_d = pat_q;
        if (cfg_we && (cfg_idx == IDX_W'(SLOT))) begin
            pat_d = cfg_pattern;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= RST_PAT;
        end else begin
            pat_q <= pat_d;
        end
    end

`ifdef MEALY_HIT_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign hit_cnt = cnt_q;

    // Clear wins over a simultaneous hit; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: rtl/mealy_pattern_matcher.sv
// Serial Mealy detector for NUM_PAT programmable patterns of PAT_LEN bits.
// Optional per-slot saturating hit counters when MEALY_HIT_COUNT_EN is defined.
module mealy_pattern_matcher
    import mealy_pkg::*;
#(
    parameter int                         PAT_LEN      = DEF_PAT_LEN,
    parameter int                         NUM_PAT      = DEF_NUM_PAT,
    parameter int                         CNT_W        = DEF_CNT_W,
    parameter logic [NUM_PAT*PAT_LEN-1:0] RST_PATTERNS = {3'b101, 3'b010}
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             i_valid,
    input  logic                             i,
    input  logic                             overlap,
    input  logic                             cfg_we,
    input  logic [clog2_min1(NUM_PAT)-1:0]   cfg_idx,
    input  logic [PAT_LEN-1:0]               cfg_pattern,
`ifdef MEALY_HIT_COUNT_EN
    input  logic                             cnt_clr,
    output logic [NUM_PAT*CNT_W-1:0]         hit_cnt,
`endif
    output logic [NUM_PAT-1:0]               o
);

    localparam int                FILL_W    = clog2_min1(PAT_LEN);
    localparam int                IDX_W     = clog2_min1(NUM_PAT);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist_q;
    logic [PAT_LEN-2:0] hist_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic [PAT_LEN-1:0] window;
    logic               match_en;

    // Newest sample sits at the LSB, oldest at the MSB, matching the pattern bit order.
    assign window   = {hist_q, i};
    assign match_en = i_valid && (fill_q == FILL_FULL);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (i_valid) begin
            hist_d = window[PAT_LEN-2:0];
            if (!overlap && (|o)) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    for (genvar k = 0; k < NUM_PAT; k++) begin : g_slot
        mealy_pat_slot #(
            .PAT_LEN (PAT_LEN),
            .IDX_W   (IDX_W),
            .SLOT    (k),
`ifdef MEALY_HIT_COUNT_EN
            .CNT_W   (CNT_W),
`endif
            .RST_PAT (RST_PATTERNS[k*PAT_LEN +: PAT_LEN])
        ) u_slot (
            .clock       (clock),
            .reset_n     (reset_n),
            .match_en    (match_en),
            .window      (window),
            .cfg_we      (cfg_we),
            .cfg_idx     (cfg_idx),
            .cfg_pattern (cfg_pattern),
`ifdef MEALY_HIT_COUNT_EN
            .cnt_clr     (cnt_clr),
            .hit_cnt     (hit_cnt[k*CNT_W +: CNT_W]),
`endif
            .hit         (o[k])
        );
    end

endmodule

// File: tb/tb_mealy_pattern_matcher.sv
// Self-checking bench for mealy_pattern_matcher: directed streams plus random traffic
// against a queue-based model of the last samples seen since reset or flush.
module tb_mealy_pattern_matcher;

   localparam int PAT_LEN = 3;
   localparam int NUM_PAT = 2;
   localparam int CNT_W   = 2;
   localparam int IDX_W   = 1;
   localparam logic [NUM_PAT*PAT_LEN-1:0] RST_PATTERNS = {3'b101, 3'b010};

   logic                 clock       = 1'b0;
   logic                 reset_n     = 1'b0;
   logic                 i_valid     = 1'b0;
   logic                 i           = 1'b0;
   logic                 overlap     = 1'b1;
   logic                 cfg_we      = 1'b0;
   logic [IDX_W-1:0]     cfg_idx     = '0;
   logic [PAT_LEN-1:0]   cfg_pattern = '0;
   logic [NUM_PAT-1:0]   o;
`ifdef MEALY_HIT_COUNT_EN
   logic                 cnt_clr     = 1'b0;
   logic [NUM_PAT*CNT_W-1:0] hit_cnt;
`endif

   int total = 0;
   int bad   = 0;

   mealy_pattern_matcher #(
      .PAT_LEN      (PAT_LEN),
      .NUM_PAT      (NUM_PAT),
      .CNT_W        (CNT_W),
      .RST_PATTERNS (RST_PATTERNS)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_valid     (i_valid),
      .i           (i),
      .overlap     (overlap),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_pattern (cfg_pattern),
`ifdef MEALY_HIT_COUNT_EN
      .cnt_clr     (cnt_clr),
      .hit_cnt     (hit_cnt),
`endif
      .o           (o)
   );

   always #5 clock = ~clock;

   // Reference model: a queue of the most recent samples since the last reset or flush,
   // the current pattern table and plain integer hit counts.
   bit                 mdlHist[$];
   logic [PAT_LEN-1:0] mdlPat [NUM_PAT];
   int                 mdlCnt [NUM_PAT];
   logic [NUM_PAT*PAT_LEN-1:0] rstPat = RST_PATTERNS;

   function automatic logic [NUM_PAT-1:0] modelHits();
      logic [NUM_PAT-1:0] r;
      logic [PAT_LEN-1:0] w;
      int n;
      n = mdlHist.size();
      r = '0;
      if (!reset_n || !i_valid || n < PAT_LEN - 1) return r;
      w = '0;
      for (int j = 0; j < PAT_LEN - 1; j++) w[PAT_LEN-1-j] = mdlHist[n-(PAT_LEN-1)+j];
      w[0] = i;
      for (int k = 0; k < NUM_PAT; k++) r[k] = (w == mdlPat[k]);
      return r;
   endfunction

   // Model state advances on every clock edge and is wiped by an asynchronous reset.
   always @(posedge clock or negedge reset_n) begin : modelUpdate
      logic [NUM_PAT-1:0] h;
      if (!reset_n) begin
         mdlHist.delete();
         for (int k = 0; k < NUM_PAT; k++) begin
            mdlPat[k] = rstPat[k*PAT_LEN +: PAT_LEN];
            mdlCnt[k] = 0;
         end
      end else begin
         h = modelHits();
`ifdef MEALY_HIT_COUNT_EN
         for (int k = 0; k < NUM_PAT; k++) begin
            if (cnt_clr) mdlCnt[k] = 0;
            else if (h[k] && mdlCnt[k] < (1 << CNT_W) - 1) mdlCnt[k] = mdlCnt[k] + 1;
         end
`endif
         if (i_valid) begin
            mdlHist.push_back(i);
            while (mdlHist.size() > PAT_LEN - 1) void'(mdlHist.pop_front());
            if (!overlap && (|h)) mdlHist.delete();
         end
         if (cfg_we && int'(cfg_idx) < NUM_PAT) mdlPat[cfg_idx] = cfg_pattern;
      end
   end

   // Every cycle, away from the active edge, the DUT outputs are set against the model.
   always @(negedge clock) begin : compareModel
      logic [NUM_PAT-1:0] e;
      e = modelHits();
      total++;
      if (o !== e) begin
         bad++;
         $display("[TB] FAIL model_o t=%0t: o=%b expected %b", $time, o, e);
      end
`ifdef MEALY_HIT_COUNT_EN
      for (int k = 0; k < NUM_PAT; k++) begin
         total++;
         if (hit_cnt[k*CNT_W +: CNT_W] !== CNT_W'(mdlCnt[k])) begin
            bad++;
            $display("[TB] FAIL model_cnt%0d t=%0t: cnt=%0d expected %0d",
                     k, $time, hit_cnt[k*CNT_W +: CNT_W], mdlCnt[k]);
         end
      end
`endif
   end

   // Drive one cycle of stimulus just after the rising edge.
   task automatic applyStimulus(input logic v, input logic b, input logic ov);
      @(posedge clock);
      #1;
      i_valid = v;
      i       = b;
      overlap = ov;
      cfg_we  = 1'b0;
`ifdef MEALY_HIT_COUNT_EN
      cnt_clr = 1'b0;
`endif
   endtask

   task automatic applyConfig(input logic [IDX_W-1:0] idx, input logic [PAT_LEN-1:0] pat);
      cfg_we      = 1'b1;
      cfg_idx     = idx;
      cfg_pattern = pat;
   endtask

   // Literal expectation on o, sampled at the falling edge of the current cycle.
   task automatic checkOutput(input string name, input logic [NUM_PAT-1:0] exp);
      @(negedge clock);
      total++;
      if (o !== exp) begin
         bad++;
         $display("[TB] FAIL %s: o=%b expected %b", name, o, exp);
      end
   endtask

`ifdef MEALY_HIT_COUNT_EN
   task automatic checkCount(input string name, input int c0, input int c1);
      total++;
      if (hit_cnt !== {CNT_W'(c1), CNT_W'(c0)}) begin
         bad++;
         $display("[TB] FAIL %s: hit_cnt=%h expected slot0=%0d slot1=%0d", name, hit_cnt, c0, c1);
      end
   endtask
`endif

   task automatic doReset();
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      i_valid = 1'b0;
      cfg_we  = 1'b0;
      @(negedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   // Ten samples, MSB of bits first, with optional idle cycles after sample gapAfter.
   task automatic runStream(input string name, input logic [9:0] bits, input logic [19:0] exp,
                            input logic ov, input int gapAfter);
      for (int s = 0; s < 10; s++) begin
         applyStimulus(1'b1, bits[9-s], ov);
         checkOutput(name, exp[(9-s)*2 +: 2]);
         if (s + 1 == gapAfter) begin
            for (int g = 0; g < 3; g++) begin
               applyStimulus(1'b0, g[0] ^ bits[9-s], ov);
               checkOutput({name, "_idle"}, 2'b00);
            end
         end
      end
   endtask

   localparam logic [9:0]  STREAM  = 10'b0110101011;
   localparam logic [19:0] EXP_OV1 = {2'b00, 2'b00, 2'b00, 2'b00, 2'b10,
                                      2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
   localparam logic [19:0] EXP_OV0 = {2'b00, 2'b00, 2'b00, 2'b00, 2'b10,
                                      2'b00, 2'b00, 2'b01, 2'b00, 2'b00};

   initial begin
      checkOutput("reset_o", 2'b00);
`ifdef MEALY_HIT_COUNT_EN
      checkCount("reset_cnt", 0, 0);
`endif
      #1;
      reset_n = 1'b1;

      runStream("stream_ov1", STREAM, EXP_OV1, 1'b1, 0);
`ifdef MEALY_HIT_COUNT_EN
      checkCount("stream_cnt", 2, 3);
`endif
      doReset();
      runStream("stream_ov0", STREAM, EXP_OV0, 1'b0, 0);
      doReset();
      runStream("stream_gap", STREAM, EXP_OV1, 1'b1, 4);

      // Pattern write coincides with sample 3; the new pattern hits at sample 4.
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("cfg_s1", 2'b00);
      applyStimulus(1'b1, 1'b1, 1'b1); checkOutput("cfg_s2", 2'b00);
      applyStimulus(1'b1, 1'b1, 1'b1); applyConfig(1'b0, 3'b110); checkOutput("cfg_s3", 2'b00);
      applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("cfg_s4", 2'b01);

      // Reset mid-stream discards history: two samples never hit, the third can.
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("rst_s1", 2'b00);
      applyStimulus(1'b1, 1'b1, 1'b1); checkOutput("rst_s2", 2'b00);
      applyStimulus(1'b1, 1'b1, 1'b1); checkOutput("rst_s3", 2'b00);
      applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("rst_s4", 2'b00);
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      i_valid = 1'b1;
      i       = 1'b1;
      checkOutput("rst_low", 2'b00);
      #1;
      reset_n = 1'b1;
      i_valid = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1); checkOutput("rst_after1", 2'b00);
      applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("rst_after2", 2'b00);
      applyStimulus(1'b1, 1'b1, 1'b1); checkOutput("rst_after3", 2'b10);

`ifdef MEALY_HIT_COUNT_EN
      // Alternating stream saturates both counters; then a clear beats a hit.
      doReset();
      for (int s = 0; s < 12; s++) begin
         applyStimulus(1'b1, s[0], 1'b1);
         checkOutput("sat_o", (s >= 2) ? (s[0] ? 2'b10 : 2'b01) : 2'b00);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("sat_idle", 2'b00);
      checkCount("sat_cnt", 3, 3);
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("clr_s1", 2'b00);
      applyStimulus(1'b1, 1'b1, 1'b1); checkOutput("clr_s2", 2'b00);
      applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("clr_s3", 2'b01);
      applyStimulus(1'b1, 1'b1, 1'b1); cnt_clr = 1'b1; checkOutput("clr_s4", 2'b10);
      applyStimulus(1'b0, 1'b0, 1'b1); checkOutput("clr_idle", 2'b00);
      checkCount("clr_cnt", 0, 0);
`endif

      // Random traffic: gaps, overlap changes, pattern writes and rare resets.
      doReset();
      for (int n = 0; n < 3000; n++) begin
         applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? ~overlap : overlap);
         if ($urandom_range(0, 15) == 0) begin
            applyConfig(IDX_W'($urandom_range(0, NUM_PAT - 1)), PAT_LEN'($urandom_range(0, 7)));
         end
`ifdef MEALY_HIT_COUNT_EN
         cnt_clr = ($urandom_range(0, 19) == 0);
`endif
         if ($urandom_range(0, 199) == 0) begin
            reset_n = 1'b0;
            @(negedge clock);
            #1;
            reset_n = 1'b1;
         end
      end

      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
